// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry type for the instruction fetch front end.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with push, pop, dominant flush and an occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type         T     = fetch_entry_t,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  T                         data_i,
    input  logic                     pop_i,
    output T                         data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i && (count_q != FULL);
        do_pop   = pop_i && (count_q != '0);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: credit-limited in-order imem requests, response queue to decode,
// and redirect handling that flushes the queue and drops stale in-flight responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter int unsigned           DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    input  logic                   redirect_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    output logic                   instr_valid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    input  logic                   instr_ready_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         discard_q, discard_d;
    logic [CW-1:0]         count;
    logic [CW:0]           credit_used;
    logic                  fire, push, pop, fifo_valid;
    logic [ADDR_WIDTH-1:0] redirect_target;
    entry_t                push_entry, head;
    logic                  unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Queued plus in-flight words never exceed DEPTH, so a kept response always has room.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, count};
    assign imem_req_o  = !rst && !redirect_i && (credit_used < CREDITS);
    assign imem_addr_o = fetch_pc_q;
    assign fire        = imem_req_o && imem_gnt_i;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        push          = 1'b0;
        outstanding_d = outstanding_q + CW'(fire) - CW'(imem_rvalid_i);
        if (redirect_i) begin
            // Everything still in flight after this cycle's return is stale.
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            discard_d  = outstanding_q - CW'(imem_rvalid_i);
        end else begin
            if (fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            end
            if (imem_rvalid_i) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + ADDR_WIDTH'(4);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign push_entry = '{pc: resp_pc_q, instr: imem_rdata_i};
    assign pop        = fifo_valid && instr_ready_i;

    fetch_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .valid_o (fifo_valid),
        .count_o (count)
    );

    assign instr_valid_o = fifo_valid;
    assign instr_o       = fifo_valid ? head.instr : INSTR_WIDTH'(NOP_INSTR);
    assign pc_o          = fifo_valid ? head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural imem with variable latency, expected-delivery
// scoreboard filled on each grant, and a monitor comparing every decode handshake.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i = 1'b0;

    fetch_unit #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .DEPTH       (4),
        .RESET_PC    (32'hBFC0_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t        sb[$];
    pend_t       pend[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          last_due = 0;
    int          gnt_cnt = 0;
    int          pop_cnt = 0;
    int          first_gnt_cyc = -1;
    logic [31:0] exp_fpc = 32'hBFC0_0000;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory response driver: words return in grant order once their due cycle arrives.
    always @(posedge clk) begin
        #1;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
    end

    // Memory/grant bookkeeping and scoreboard producer.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            pend.delete();
            exp_fpc       = 32'hBFC0_0000;
            last_due      = 0;
            first_gnt_cyc = -1;
        end else begin
            if (redirect_i) begin
                sb.delete();
                exp_fpc = {redirect_pc_i[31:2], 2'b00};
            end
            if (imem_rvalid_i) void'(pend.pop_front());
            if (imem_req_o && imem_gnt_i) begin
                pend_t p;
                check("req_addr", 64'(imem_addr_o), 64'(exp_fpc));
                p.addr = imem_addr_o;
                p.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                last_due = p.due;
                pend.push_back(p);
                sb.push_back('{pc: imem_addr_o, instr: mem_word(imem_addr_o)});
                exp_fpc = exp_fpc + 32'd4;
                gnt_cnt++;
                if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
            end
        end
    end

    // Monitor: consumes the scoreboard on every effective decode handshake.
    always @(negedge clk) begin
        if (!rst && !redirect_i) begin
            if (instr_valid_o && instr_ready_i) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL deliver_unexpected: got pc %h instr %h expected none", pc_o, instr_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("deliver_pc", 64'(pc_o), 64'(e.pc));
                    check("deliver_instr", 64'(instr_o), 64'(e.instr));
                end
                pop_cnt++;
            end else if (!instr_valid_o) begin
                check("idle_instr", 64'(instr_o), 64'h13);
                check("idle_pc", 64'(pc_o), 64'h0);
            end
        end
    end

    task automatic cyc_in();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b0;
        instr_ready_i = 1'b0;
        repeat (2) cyc_in();
        gnt_cnt = 0;
        rst     = 1'b0;
    endtask

    initial begin
        int  nvalid;
        bit  found;

        // Reset state
        repeat (3) cyc_in();
        @(negedge clk);
        check("rst_valid", 64'(instr_valid_o), 64'h0);
        check("rst_instr", 64'(instr_o), 64'h13);
        check("rst_pc", 64'(pc_o), 64'h0);
        check("rst_req", 64'(imem_req_o), 64'h0);

        // Streaming, L=1, always ready
        cyc_in();
        rst = 1'b0; imem_gnt_i = 1'b1; instr_ready_i = 1'b1; lat = 1;
        @(negedge clk);
        check("first_req", 64'(imem_req_o), 64'h1);
        check("first_addr", 64'(imem_addr_o), 64'hBFC0_0000);
        cyc_in();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (instr_valid_o) begin
                found = 1;
                check("first_valid_latency", 64'(cyc - first_gnt_cyc), 64'd2);
                check("first_pc", 64'(pc_o), 64'hBFC0_0000);
                check("first_instr", 64'(instr_o), 64'hAC97_9BDF);
            end
            cyc_in();
        end
        check("first_valid_seen", 64'(found), 64'h1);
        nvalid = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (instr_valid_o) nvalid++;
            cyc_in();
        end
        check("throughput", 64'(nvalid), 64'd15);

        // Decode stalled: credits cap grants at DEPTH
        do_reset();
        imem_gnt_i = 1'b1; lat = 1;
        repeat (10) cyc_in();
        @(negedge clk);
        check("stall_grants", 64'(gnt_cnt), 64'd4);
        check("stall_req_low", 64'(imem_req_o), 64'h0);
        cyc_in();
        instr_ready_i = 1'b1;
        @(negedge clk);
        check("stall_pop_cycle_req", 64'(imem_req_o), 64'h0);
        check("stall_pop_cycle_valid", 64'(instr_valid_o), 64'h1);
        cyc_in();
        @(negedge clk);
        check("stall_req_reassert", 64'(imem_req_o), 64'h1);
        repeat (8) cyc_in();

        // Redirect with two responses outstanding
        do_reset();
        lat = 3; instr_ready_i = 1'b1; imem_gnt_i = 1'b1;
        cyc_in();
        cyc_in();
        imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'hBFC0_0103;
        @(negedge clk);
        check("redir_req_low", 64'(imem_req_o), 64'h0);
        check("redir_two_granted", 64'(gnt_cnt), 64'd2);
        cyc_in();
        redirect_i = 1'b0; imem_gnt_i = 1'b1;
        @(negedge clk);
        check("redir_next_addr", 64'(imem_addr_o), 64'hBFC0_0100);
        found = 0;
        for (int i = 0; i < 12; i++) begin
            cyc_in();
            @(negedge clk);
            if (instr_valid_o && !found) begin
                found = 1;
                check("redir_first_pc", 64'(pc_o), 64'hBFC0_0100);
                check("redir_first_instr", 64'(instr_o), 64'hAC97_9ADF);
            end
        end
        check("redir_delivered", 64'(found), 64'h1);

        // Redirect coincident with rvalid and pop, L=2 steady stream
        cyc_in();
        lat = 2;
        repeat (10) cyc_in();
        redirect_i = 1'b1; redirect_pc_i = 32'hBFC0_0200;
        @(negedge clk);
        check("coinc_valid_before", 64'(instr_valid_o), 64'h1);
        check("coinc_rvalid_before", 64'(imem_rvalid_i), 64'h1);
        cyc_in();
        redirect_i = 1'b0;
        @(negedge clk);
        check("coinc_flushed", 64'(instr_valid_o), 64'h0);
        check("coinc_addr", 64'(imem_addr_o), 64'hBFC0_0200);
        repeat (12) cyc_in();

        // Address wrap
        lat = 1;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF9;
        cyc_in();
        redirect_i = 1'b0;
        @(negedge clk);
        check("wrap_addr", 64'(imem_addr_o), 64'hFFFF_FFF8);
        repeat (10) cyc_in();

        // Reset while three entries are queued
        do_reset();
        lat = 1; imem_gnt_i = 1'b1;
        repeat (3) cyc_in();
        imem_gnt_i = 1'b0;
        repeat (4) cyc_in();
        @(negedge clk);
        check("held_valid", 64'(instr_valid_o), 64'h1);
        check("held_grants", 64'(gnt_cnt), 64'd3);
        cyc_in();
        rst = 1'b1;
        cyc_in();
        rst = 1'b0; imem_gnt_i = 1'b1; instr_ready_i = 1'b1;
        @(negedge clk);
        check("midrst_valid", 64'(instr_valid_o), 64'h0);
        check("midrst_instr", 64'(instr_o), 64'h13);
        check("midrst_pc", 64'(pc_o), 64'h0);
        check("midrst_addr", 64'(imem_addr_o), 64'hBFC0_0000);
        repeat (6) cyc_in();

        // Random grant, latency, ready and redirects
        pop_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            imem_gnt_i    = ($urandom_range(0, 3) != 0);
            instr_ready_i = ($urandom_range(0, 3) != 0);
            lat           = $urandom_range(1, 3);
            redirect_i    = ($urandom_range(0, 19) == 0);
            redirect_pc_i = $urandom;
            cyc_in();
        end
        redirect_i = 1'b0; imem_gnt_i = 1'b0; instr_ready_i = 1'b1;
        repeat (12) cyc_in();
        check("random_progress", 64'(pop_cnt > 60), 64'h1);
        check("random_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that produces the `instr` stream the control unit decodes. It also acts on the control-flow redirect resolved downstream. It holds the fetch PC, issues in-order requests to instruction memory, and buffers returned words with their PCs in a small queue. It presents them to decode over a valid/ready handshake, and on redirect it flushes the queue and drops stale in-flight responses.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: PC/address width.
- `INSTR_WIDTH`, 32: instruction width.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 32'hBFC00000: first fetch address after reset.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock.
  - `rst`  in  1  reset.
- Instruction memory request:
  - `imem_req_o`  out  1  request valid.
  - `imem_addr_o`  out  ADDR_WIDTH  request address (word aligned).
  - `imem_gnt_i`  in  1  request accepted this cycle.
- Instruction memory response:
  - `imem_rvalid_i`  in  1  response valid. Responses are in order, one per grant, latency ≥1 cycle.
  - `imem_rdata_i`  in  INSTR_WIDTH  response data.
- Redirect:
  - `redirect_i`  in  1  taken branch/jump; restart fetch.
  - `redirect_pc_i`  in  ADDR_WIDTH  new PC; bits [1:0] ignored.
- Decode side:
  - `instr_valid_o`  out  1  queue head valid.
  - `instr_o`  out  INSTR_WIDTH  head instruction, or NOP 32'h00000013 when empty.
  - `pc_o`  out  ADDR_WIDTH  head PC, or 0 when empty.
  - `instr_ready_i`  in  1  decode consumes head.

## Operation
- State:
  - `fetch_pc`: next address to request.
  - `resp_pc`: PC of next kept response.
  - `outstanding`: granted, not yet returned; $clog2(DEPTH)+1 bits.
  - `discard`: responses still to drop.
  - Queue of {pc, instr}.
- Issue:
  - `imem_req_o` = !rst && !redirect_i && (outstanding + count < DEPTH).
  - `imem_addr_o` = `fetch_pc`.
  - On req&&gnt: `fetch_pc` += 4, `outstanding`++.
- Response (rvalid): `outstanding`--.
  - If `discard` > 0: drop the word, `discard`--.
  - Otherwise push {`resp_pc`, rdata} and `resp_pc` += 4.
  - The credit rule guarantees a push never hits a full queue.
- Pop: `instr_valid_o` && `instr_ready_i` removes the head.
- Redirect (priority over pop, push and issue in the same cycle):
  - Queue flushed.
  - `fetch_pc` = `resp_pc` = {`redirect_pc_i`[ADDR_WIDTH-1:2], 2'b00}.
  - `discard` = outstanding after this cycle's rvalid decrement.
  - An rvalid in the redirect cycle is dropped regardless of `discard`.
- Issue continues while `discard` > 0. New responses follow the stale ones in order and are kept once `discard` reaches 0.
- Address wrap: `fetch_pc` + 4 wraps modulo 2^ADDR_WIDTH, no special handling.

## Timing
- Reset values:
  - Queue empty, `instr_valid_o`=0, `instr_o`=NOP, `pc_o`=0, `imem_req_o`=0.
  - `fetch_pc`=`resp_pc`=RESET_PC; `outstanding`=`discard`=0.
- Reset mid-operation: all of the above within one edge. Responses arriving after reset release for pre-reset grants are a system error; memory is reset together with this block.
- First request: cycle after `rst` deasserts, address RESET_PC.
- Latency: gnt in cycle N with memory latency L gives rvalid at N+L and `instr_valid_o` at N+L+1. No combinational rdata→instr_o path.
- Throughput: 1 instr/cycle sustained when DEPTH ≥ L+2 and decode is always ready.
- Queue full with decode stalled: `imem_req_o` drops once outstanding+count = DEPTH. It reasserts the cycle after a pop frees a credit.
- Simultaneous push and pop on the queue: both occur; count unchanged.

## Structure
- `fetch_pkg`: NOP_INSTR, RESET_PC default, `fetch_entry_t` struct {pc, instr}.
- Sub-module `fetch_fifo`: synchronous DEPTH-entry FIFO of `fetch_entry_t` with push, pop and flush (flush dominant), plus count output.
- Credit, `discard` and PC logic stay in `fetch_unit`.

## Test plan
- Reset then always-grant, L=1, ready=1 → requests to BFC00000, BFC00004, …; first `instr_valid_o` 2 cycles after first gnt; pc_o increments by 4 every cycle.
- `instr_ready_i`=0 for 10 cycles, L=1, DEPTH=4 → exactly 4 grants total, `imem_req_o` low until the first pop, no lost or duplicated entries.
- Redirect to BFC00103 with 2 requests outstanding → next request address BFC00100, 2 stale responses dropped, first delivered pc_o=BFC00100.
- Redirect coincident with rvalid and pop → queue empty next cycle, rvalid word not delivered, `discard` = remaining outstanding.
- `rst` asserted while queue holds 3 entries → next cycle `instr_valid_o`=0, instr_o=00000013, fetch restarts at RESET_PC.
- Random gnt/rvalid latency (1–3) with random ready and redirects against a reference model → the delivered {pc, instr} sequence matches program order from each redirect target.
